// File: rtl/riscv_defines.sv
// Shared definitions for the instruction port arbiter.
// Master identifiers and default outstanding depth.
package riscv_defines;

  typedef enum logic {
    ARB_M_CORE = 1'b0,
    ARB_M_AUX  = 1'b1
  } arb_master_e;

  localparam int ARB_MAX_OUTSTANDING_DEF = 2;

endpackage

// File: rtl/riscv_arb_id_fifo.sv
// 1-bit-wide ID FIFO recording which master owns each
// outstanding fetch. Ports: push_i/data_i, pop_i, full_o, empty_o, head_o.
module riscv_arb_id_fifo
  import riscv_defines::*;
#(
  parameter int DEPTH = ARB_MAX_OUTSTANDING_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // A push into a full FIFO is only legal with a
  // simultaneous pop freeing the head slot.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d        = nxt(wr_q);
    end
    if (do_pop) begin
      rd_d = nxt(rd_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/riscv_instr_port_arbiter.sv
// Round-robin arbiter sharing one instruction memory port
// between core fetch (m0) and aux fetcher (m1), with
// request locking and an ID FIFO routing rvalid back.
// Ports: mX_req/addr in, mX_gnt/rvalid/err out, m_rdata_o,
// instr_* memory side, busy_o, spurious_rvalid_o.
// Define RISCV_ARB_PMP_ERR_EN to route instr_err_pmp_i.
module riscv_instr_port_arbiter
  import riscv_defines::*;
#(
  parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  output logic        m0_rvalid_o,
  output logic        m1_rvalid_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic [31:0] m_rdata_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_pmp_i,
  output logic        busy_o,
  output logic        spurious_rvalid_o
);

  arb_master_e sel;
  arb_master_e prio_q, prio_d;
  arb_master_e lock_id_q, lock_id_d;
  logic        lock_valid_q, lock_valid_d;
  logic        spur_q, spur_d;
  logic        sel_req;
  logic [31:0] sel_addr;
  logic        gnt;
  logic        pop;
  logic        fifo_full, fifo_empty, fifo_head;

  always_comb begin
    sel = prio_q;
    unique case (1'b1)
      lock_valid_q:
        sel = lock_id_q;
      (~lock_valid_q & m0_req_i & ~m1_req_i):
        sel = ARB_M_CORE;
      (~lock_valid_q & m1_req_i & ~m0_req_i):
        sel = ARB_M_AUX;
      default:
        sel = prio_q;
    endcase
  end

  assign sel_req  = (sel == ARB_M_AUX) ? m1_req_i
                                       : m0_req_i;
  assign sel_addr = (sel == ARB_M_AUX) ? m1_addr_i
                                       : m0_addr_i;

  assign instr_req_o  = sel_req & ~fifo_full;
  assign instr_addr_o = sel_req ? sel_addr : '0;

  assign gnt      = instr_req_o & instr_gnt_i;
  assign m0_gnt_o = gnt & (sel == ARB_M_CORE);
  assign m1_gnt_o = gnt & (sel == ARB_M_AUX);

  // Responses with nothing outstanding are dropped and
  // only flagged.
  assign pop         = instr_rvalid_i & ~fifo_empty;
  assign m0_rvalid_o = pop & ~fifo_head;
  assign m1_rvalid_o = pop & fifo_head;
  assign m_rdata_o   = instr_rdata_i;

`ifdef RISCV_ARB_PMP_ERR_EN
  assign m0_err_o = m0_rvalid_o & instr_err_pmp_i;
  assign m1_err_o = m1_rvalid_o & instr_err_pmp_i;
`else
  logic unused_err;
  assign unused_err = instr_err_pmp_i;
  assign m0_err_o   = 1'b0;
  assign m1_err_o   = 1'b0;
`endif

  assign busy_o = ~fifo_empty | m0_req_i | m1_req_i;
  assign spurious_rvalid_o = spur_q;

  always_comb begin
    prio_d       = prio_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    spur_d       = spur_q | (instr_rvalid_i & fifo_empty);
    if (gnt) begin
      prio_d = (sel == ARB_M_CORE) ? ARB_M_AUX
                                   : ARB_M_CORE;
      lock_valid_d = 1'b0;
    end else if (lock_valid_q & ~sel_req) begin
      // Owner withdrew mid-handshake: drop the lock.
      lock_valid_d = 1'b0;
    end else if (instr_req_o) begin
      lock_valid_d = 1'b1;
      lock_id_d    = sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q       <= ARB_M_CORE;
      lock_valid_q <= 1'b0;
      lock_id_q    <= ARB_M_CORE;
      spur_q       <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      spur_q       <= spur_d;
    end
  end

  riscv_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (gnt),
    .data_i  (sel == ARB_M_AUX),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_riscv_instr_port_arbiter.sv
// Self-checking bench for riscv_instr_port_arbiter.
// Transaction-level model plus directed literal checks.
module tb_riscv_instr_port_arbiter;

  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req_i = 1'b0;
  logic [31:0] m0_addr_i = '0;
  logic        m1_req_i = 1'b0;
  logic [31:0] m1_addr_i = '0;
  logic        m0_gnt_o, m1_gnt_o;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic        m0_err_o, m1_err_o;
  logic [31:0] m_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_pmp_i = 1'b0;
  logic        busy_o, spurious_rvalid_o;

  always #5 clk = ~clk;

  riscv_instr_port_arbiter #(
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .m0_req_i          (m0_req_i),
    .m0_addr_i         (m0_addr_i),
    .m1_req_i          (m1_req_i),
    .m1_addr_i         (m1_addr_i),
    .m0_gnt_o          (m0_gnt_o),
    .m1_gnt_o          (m1_gnt_o),
    .m0_rvalid_o       (m0_rvalid_o),
    .m1_rvalid_o       (m1_rvalid_o),
    .m0_err_o          (m0_err_o),
    .m1_err_o          (m1_err_o),
    .m_rdata_o         (m_rdata_o),
    .instr_req_o       (instr_req_o),
    .instr_addr_o      (instr_addr_o),
    .instr_gnt_i       (instr_gnt_i),
    .instr_rvalid_i    (instr_rvalid_i),
    .instr_rdata_i     (instr_rdata_i),
    .instr_err_pmp_i   (instr_err_pmp_i),
    .busy_o            (busy_o),
    .spurious_rvalid_o (spurious_rvalid_o)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Model: owners of outstanding fetches in order,
  // preferred master, master waiting for a grant.
  bit mq[$];
  int pref = 0;
  int stuck = -1;
  bit spur = 0;

  int c;
  bit ask, room;
  bit e_req, e_g0, e_g1, e_rv0, e_rv1;
  bit e_er0, e_er1, e_busy;
  logic [31:0] e_addr;

  // Observation logs for directed checks.
  logic [31:0] gnt_bits, rv_bits;
  int gnt_n, rv_n, err_n;
  logic [31:0] addr_log[$];
  logic l_req, l_busy, l_spur;
  logic [31:0] l_addr;

  initial begin : mon
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        pref  = 0;
        stuck = -1;
        spur  = 0;
      end
      if (stuck >= 0) c = stuck;
      else if (m0_req_i && !m1_req_i) c = 0;
      else if (m1_req_i && !m0_req_i) c = 1;
      else c = pref;
      ask    = (c == 1) ? m1_req_i : m0_req_i;
      room   = mq.size() < MO;
      e_req  = ask && room;
      e_addr = !ask ? 32'h0 :
               (c == 1) ? m1_addr_i : m0_addr_i;
      e_g0   = e_req && instr_gnt_i && c == 0;
      e_g1   = e_req && instr_gnt_i && c == 1;
      e_rv0  = 0;
      e_rv1  = 0;
      e_er0  = 0;
      e_er1  = 0;
      if (instr_rvalid_i && mq.size() > 0) begin
        if (mq[0]) e_rv1 = 1;
        else e_rv0 = 1;
`ifdef RISCV_ARB_PMP_ERR_EN
        e_er0 = e_rv0 && instr_err_pmp_i;
        e_er1 = e_rv1 && instr_err_pmp_i;
`endif
      end
      e_busy = mq.size() != 0 || m0_req_i || m1_req_i;

      chk("req", instr_req_o, e_req);
      chk("addr", instr_addr_o, e_addr);
      chk("m0_gnt", m0_gnt_o, e_g0);
      chk("m1_gnt", m1_gnt_o, e_g1);
      chk("m0_rvalid", m0_rvalid_o, e_rv0);
      chk("m1_rvalid", m1_rvalid_o, e_rv1);
      chk("m0_err", m0_err_o, e_er0);
      chk("m1_err", m1_err_o, e_er1);
      chk("rdata", m_rdata_o, instr_rdata_i);
      chk("busy", busy_o, e_busy);
      chk("spurious", spurious_rvalid_o, spur);

      if (m0_gnt_o || m1_gnt_o) begin
        gnt_bits = {gnt_bits[30:0], m1_gnt_o};
        gnt_n++;
      end
      if (m0_rvalid_o || m1_rvalid_o) begin
        rv_bits = {rv_bits[30:0], m1_rvalid_o};
        rv_n++;
      end
      if (m0_err_o || m1_err_o) err_n++;
      if (instr_req_o) addr_log.push_back(instr_addr_o);
      l_req  = instr_req_o;
      l_busy = busy_o;
      l_spur = spurious_rvalid_o;
      l_addr = instr_addr_o;

      if (!rst) begin
        if (instr_rvalid_i) begin
          if (mq.size() > 0) void'(mq.pop_front());
          else spur = 1;
        end
        if (e_req && instr_gnt_i) begin
          mq.push_back(c[0]);
          pref  = 1 - c;
          stuck = -1;
        end else if (stuck >= 0 && !ask) begin
          stuck = -1;
        end else if (e_req) begin
          stuck = c;
        end
      end
    end
  end

  task automatic clr();
    gnt_bits = '0;
    rv_bits  = '0;
    gnt_n    = 0;
    rv_n     = 0;
    err_n    = 0;
    addr_log.delete();
  endtask

  task automatic cyc(input bit r0,
                     input logic [31:0] a0,
                     input bit r1,
                     input logic [31:0] a1,
                     input bit g,
                     input bit rv,
                     input bit er);
    m0_req_i        = r0;
    m0_addr_i       = a0;
    m1_req_i        = r1;
    m1_addr_i       = a1;
    instr_gnt_i     = g;
    instr_rvalid_i  = rv;
    instr_err_pmp_i = er;
    instr_rdata_i   = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    m0_req_i       = 0;
    m1_req_i       = 0;
    instr_gnt_i    = 0;
    instr_rvalid_i = 0;
    rst            = 1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Reset state and m0-only stream.
    do_reset();
    idle();
    chk("rst req", l_req, 0);
    chk("rst busy", l_busy, 0);
    chk("rst spur", l_spur, 0);
    chk("rst addr", l_addr, 0);
    clr();
    cyc(1, 32'h100, 0, 0, 1, 0, 0);
    cyc(1, 32'h104, 0, 0, 1, 1, 0);
    cyc(1, 32'h108, 0, 0, 1, 1, 0);
    cyc(1, 32'h10C, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("t1 gnt_n", gnt_n, 4);
    chk("t1 gnt seq", gnt_bits, 32'h0);
    chk("t1 rv_n", rv_n, 4);
    chk("t1 rv seq", rv_bits, 32'h0);
    chk("t1 addr0", addr_log[0], 32'h100);
    chk("t1 addr1", addr_log[1], 32'h104);
    chk("t1 addr2", addr_log[2], 32'h108);
    chk("t1 addr3", addr_log[3], 32'h10C);

    // Both masters: alternate grants and responses.
    do_reset();
    clr();
    cyc(1, 32'h200, 1, 32'h300, 1, 0, 0);
    repeat (3) cyc(1, 32'h200, 1, 32'h300, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("t2 gnt_n", gnt_n, 4);
    chk("t2 gnt seq", gnt_bits, 32'b0101);
    chk("t2 rv_n", rv_n, 4);
    chk("t2 rv seq", rv_bits, 32'b0101);
    chk("t2 addr1", addr_log[1], 32'h300);

    // m1 locked while gnt held low, m0 joins.
    do_reset();
    clr();
    cyc(0, 0, 1, 32'h400, 0, 0, 0);
    cyc(1, 32'h500, 1, 32'h400, 0, 0, 0);
    cyc(1, 32'h500, 1, 32'h400, 0, 0, 0);
    chk("t3 lock addr", l_addr, 32'h400);
    cyc(1, 32'h500, 1, 32'h400, 1, 0, 0);
    cyc(1, 32'h500, 1, 32'h400, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("t3 gnt_n", gnt_n, 2);
    chk("t3 gnt seq", gnt_bits, 32'b10);
    chk("t3 rv seq", rv_bits, 32'b10);
    chk("t3 addr4", addr_log[4], 32'h500);

    // FIFO full and push+pop in one cycle.
    do_reset();
    clr();
    cyc(1, 32'h600, 0, 0, 1, 0, 0);
    cyc(1, 32'h604, 0, 0, 1, 0, 0);
    cyc(1, 32'h608, 0, 0, 1, 0, 0);
    chk("t4 full req", l_req, 0);
    chk("t4 full busy", l_busy, 1);
    cyc(1, 32'h608, 0, 0, 1, 1, 0);
    chk("t4 full pop req", l_req, 0);
    cyc(1, 32'h608, 0, 0, 1, 1, 0);
    chk("t4 push+pop req", l_req, 1);
    cyc(1, 32'h60C, 0, 0, 1, 0, 0);
    cyc(1, 32'h610, 0, 0, 1, 0, 0);
    chk("t4 refull req", l_req, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle();
    chk("t4 drained busy", l_busy, 0);
    chk("t4 no spur", l_spur, 0);
    chk("t4 gnt_n", gnt_n, 4);
    chk("t4 rv_n", rv_n, 4);

    // rvalid with nothing outstanding.
    do_reset();
    clr();
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("t5 rv_n", rv_n, 0);
    idle();
    chk("t5 spur set", l_spur, 1);
    repeat (3) idle();
    chk("t5 spur sticky", l_spur, 1);
    do_reset();
    idle();
    chk("t5 spur clr", l_spur, 0);

    // Reset with two in flight, then error return.
    clr();
    cyc(1, 32'h700, 0, 0, 1, 0, 0);
    cyc(1, 32'h704, 0, 0, 1, 0, 0);
    do_reset();
    idle();
    chk("t6 busy", l_busy, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle();
    chk("t6 late spur", l_spur, 1);
    clr();
    cyc(1, 32'h708, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t6 rv_n", rv_n, 1);
    chk("t6 rv seq", rv_bits, 32'b0);
`ifdef RISCV_ARB_PMP_ERR_EN
    chk("t6 err_n", err_n, 1);
`else
    chk("t6 err_n", err_n, 0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
